// File: rtl/alu_issue_ctrl_pkg.sv
// rtl/alu_issue_ctrl_pkg.sv - shared ALU codes, MIPS decode constants and issue FSM states
package alu_issue_ctrl_pkg;

  typedef enum logic [3:0] {
    ALUC_ADDU = 4'b0000,
    ALUC_SUBU = 4'b0001,
    ALUC_ADD  = 4'b0010,
    ALUC_SUB  = 4'b0011,
    ALUC_AND  = 4'b0100,
    ALUC_OR   = 4'b0101,
    ALUC_XOR  = 4'b0110,
    ALUC_NOR  = 4'b0111,
    ALUC_LUI  = 4'b1000,
    ALUC_SLTU = 4'b1010,
    ALUC_SLT  = 4'b1011,
    ALUC_SRA  = 4'b1100,
    ALUC_SRL  = 4'b1101,
    ALUC_SLL  = 4'b1110
  } aluc_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;

  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_SLLV = 6'b000100;
  localparam logic [5:0] FN_SRLV = 6'b000110;
  localparam logic [5:0] FN_SRAV = 6'b000111;
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_NOR  = 6'b100111;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLTU = 6'b101011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {ASEL_ZERO, ASEL_RS, ASEL_SHAMT} a_sel_e;
  typedef enum logic [1:0] {BSEL_ZERO, BSEL_RT, BSEL_IMM} b_sel_e;
  typedef enum logic {EXT_ZERO, EXT_SIGN} ext_e;

  // CLS_TRAP_OV marks ADD/SUB forms whose signed overflow suppresses writeback
  typedef enum logic {CLS_PLAIN, CLS_TRAP_OV} cls_e;

  function automatic logic [31:0] ext_imm(input logic [15:0] imm, input ext_e ext);
    return (ext == EXT_SIGN) ? {{16{imm[15]}}, imm} : {16'h0000, imm};
  endfunction

endpackage

// File: rtl/alu_issue_dec.sv
// rtl/alu_issue_dec.sv - combinational MIPS instruction decode into ALU op, operand selects and writeback target
module alu_issue_dec
  import alu_issue_ctrl_pkg::*;
(
  input  logic [31:0] i_instr,
  output aluc_e       o_aluc,
  output a_sel_e      o_a_sel,
  output b_sel_e      o_b_sel,
  output ext_e        o_ext,
  output logic [4:0]  o_waddr,
  output cls_e        o_cls,
  output logic        o_illegal
);

  logic [5:0] w_op;
  logic [5:0] w_funct;
  logic       w_unused_rs;

  assign w_op        = i_instr[31:26];
  assign w_funct     = i_instr[5:0];
  // rs register index is resolved outside; only its value reaches this block
  assign w_unused_rs = ^i_instr[25:21];

  always_comb begin
    o_aluc    = ALUC_ADDU;
    o_a_sel   = ASEL_ZERO;
    o_b_sel   = BSEL_ZERO;
    o_ext     = EXT_ZERO;
    o_waddr   = 5'd0;
    o_cls     = CLS_PLAIN;
    o_illegal = 1'b1;

    if (w_op == OP_RTYPE) begin
      o_illegal = 1'b0;
      o_a_sel   = ASEL_RS;
      o_b_sel   = BSEL_RT;
      o_waddr   = i_instr[15:11];
      case (w_funct)
        FN_ADD:  begin o_aluc = ALUC_ADD; o_cls = CLS_TRAP_OV; end
        FN_ADDU: o_aluc = ALUC_ADDU;
        FN_SUB:  begin o_aluc = ALUC_SUB; o_cls = CLS_TRAP_OV; end
        FN_SUBU: o_aluc = ALUC_SUBU;
        FN_AND:  o_aluc = ALUC_AND;
        FN_OR:   o_aluc = ALUC_OR;
        FN_XOR:  o_aluc = ALUC_XOR;
        FN_NOR:  o_aluc = ALUC_NOR;
        FN_SLT:  o_aluc = ALUC_SLT;
        FN_SLTU: o_aluc = ALUC_SLTU;
        FN_SLL:  begin o_aluc = ALUC_SLL; o_a_sel = ASEL_SHAMT; end
        FN_SRL:  begin o_aluc = ALUC_SRL; o_a_sel = ASEL_SHAMT; end
        FN_SRA:  begin o_aluc = ALUC_SRA; o_a_sel = ASEL_SHAMT; end
        FN_SLLV: o_aluc = ALUC_SLL;
        FN_SRLV: o_aluc = ALUC_SRL;
        FN_SRAV: o_aluc = ALUC_SRA;
        default: o_illegal = 1'b1;
      endcase
    end else begin
      o_illegal = 1'b0;
      o_a_sel   = ASEL_RS;
      o_b_sel   = BSEL_IMM;
      o_waddr   = i_instr[20:16];
      case (w_op)
        OP_ADDI:  begin o_aluc = ALUC_ADD; o_ext = EXT_SIGN; o_cls = CLS_TRAP_OV; end
        OP_ADDIU: begin o_aluc = ALUC_ADDU; o_ext = EXT_SIGN; end
        OP_SLTI:  begin o_aluc = ALUC_SLT; o_ext = EXT_SIGN; end
        OP_SLTIU: begin o_aluc = ALUC_SLTU; o_ext = EXT_SIGN; end
        OP_ANDI:  o_aluc = ALUC_AND;
        OP_ORI:   o_aluc = ALUC_OR;
        OP_XORI:  o_aluc = ALUC_XOR;
        OP_LUI:   o_aluc = ALUC_LUI;
        default:  o_illegal = 1'b1;
      endcase
    end

    // Unknown encodings issue a harmless ADDU 0+0 with no target
    if (o_illegal) begin
      o_aluc  = ALUC_ADDU;
      o_a_sel = ASEL_ZERO;
      o_b_sel = BSEL_ZERO;
      o_ext   = EXT_ZERO;
      o_waddr = 5'd0;
      o_cls   = CLS_PLAIN;
    end
  end

endmodule

// File: rtl/alu_issue_ctrl.sv
// rtl/alu_issue_ctrl.sv - issues one decoded MIPS ALU instruction to an external ALU and returns its writeback
module alu_issue_ctrl
  import alu_issue_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [3:0]  alu_aluc,
  input  logic [31:0] alu_r,
  input  logic        alu_zero,
  input  logic        alu_carry,
  input  logic        alu_negative,
  input  logic        alu_overflow,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_wdata,
  output logic [4:0]  out_waddr,
  output logic        out_we,
  output logic [3:0]  out_flags,
  output logic        out_exc_ov,
  output logic        out_illegal
);

  aluc_e       w_aluc;
  a_sel_e      w_a_sel;
  b_sel_e      w_b_sel;
  ext_e        w_ext;
  logic [4:0]  w_waddr;
  cls_e        w_cls;
  logic        w_illegal;
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic        w_exc_ov;

  state_e      r_state;
  logic [31:0] r_alu_a;
  logic [31:0] r_alu_b;
  logic [3:0]  r_alu_aluc;
  logic [4:0]  r_waddr;
  logic        r_trap_ov;
  logic        r_illegal;
  logic        r_out_valid;
  logic [31:0] r_out_wdata;
  logic [4:0]  r_out_waddr;
  logic        r_out_we;
  logic [3:0]  r_out_flags;
  logic        r_out_exc_ov;
  logic        r_out_illegal;

  alu_issue_dec u_dec (
    .i_instr   (instr),
    .o_aluc    (w_aluc),
    .o_a_sel   (w_a_sel),
    .o_b_sel   (w_b_sel),
    .o_ext     (w_ext),
    .o_waddr   (w_waddr),
    .o_cls     (w_cls),
    .o_illegal (w_illegal)
  );

  always_comb begin
    case (w_a_sel)
      ASEL_RS:    w_a = rs_val;
      ASEL_SHAMT: w_a = {27'd0, instr[10:6]};
      default:    w_a = 32'd0;
    endcase
    case (w_b_sel)
      BSEL_RT:  w_b = rt_val;
      BSEL_IMM: w_b = ext_imm(instr[15:0], w_ext);
      default:  w_b = 32'd0;
    endcase
  end

  assign w_exc_ov = r_trap_ov & alu_overflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_alu_a       <= 32'd0;
      r_alu_b       <= 32'd0;
      r_alu_aluc    <= 4'd0;
      r_waddr       <= 5'd0;
      r_trap_ov     <= 1'b0;
      r_illegal     <= 1'b0;
      r_out_valid   <= 1'b0;
      r_out_wdata   <= 32'd0;
      r_out_waddr   <= 5'd0;
      r_out_we      <= 1'b0;
      r_out_flags   <= 4'd0;
      r_out_exc_ov  <= 1'b0;
      r_out_illegal <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_alu_a    <= w_a;
            r_alu_b    <= w_b;
            r_alu_aluc <= w_aluc;
            r_waddr    <= w_waddr;
            r_trap_ov  <= (w_cls == CLS_TRAP_OV);
            r_illegal  <= w_illegal;
            r_state    <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          r_out_wdata   <= alu_r;
          r_out_waddr   <= r_waddr;
          r_out_flags   <= {alu_zero, alu_carry, alu_negative, alu_overflow};
          r_out_exc_ov  <= w_exc_ov;
          r_out_illegal <= r_illegal;
          r_out_we      <= !r_illegal && (r_waddr != 5'd0) && !w_exc_ov;
          r_out_valid   <= 1'b1;
          r_state       <= ST_DONE;
        end
        ST_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == ST_IDLE);
  assign alu_a       = r_alu_a;
  assign alu_b       = r_alu_b;
  assign alu_aluc    = r_alu_aluc;
  assign out_valid   = r_out_valid;
  assign out_wdata   = r_out_wdata;
  assign out_waddr   = r_out_waddr;
  assign out_we      = r_out_we;
  assign out_flags   = r_out_flags;
  assign out_exc_ov  = r_out_exc_ov;
  assign out_illegal = r_out_illegal;

endmodule
